cpu_clk_gen: RTL and testbench

- Synthesizable replacement for the clocking-wizard core that derives the CPU clock from the 100 MHz board clock.
- Divides clk_in1 by an integer DIV to produce clk_out1. The default divide gives 100 MHz → 25 MHz.
- Also provides a one-cycle clock-enable strobe in the clk_in1 domain and a sticky locked flag.
- Sits at the top level between the board oscillator and the CPU core.

---
 rtl/cpu_clk_gen_pkg.sv | 23 ++
 rtl/cpu_clk_lock_mon.sv | 46 ++++
 rtl/cpu_clk_gen.sv | 64 ++++++
 tb/tb_cpu_clk_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_clk_gen_pkg.sv
// Shared limits and legality helpers for the CPU clock generator.
package cpu_clk_gen_pkg;

    localparam int DIV_MIN  = 2;
    localparam int DIV_MAX  = 65535;
    localparam int LOCK_MIN = 1;

    // True when the divide ratio lies in the supported range.
    function automatic bit div_legal(input int div);
        return (div >= DIV_MIN) && (div <= DIV_MAX);
    endfunction

    // True when the lock period count is usable.
    function automatic bit lock_legal(input int lock_cycles);
        return lock_cycles >= LOCK_MIN;
    endfunction

    // Width of a counter that must hold values 0..max, never narrower than 1.
    function automatic int width_for(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/cpu_clk_lock_mon.sv
// Saturating count of completed output periods and the sticky locked flag.
module cpu_clk_lock_mon
    import cpu_clk_gen_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk_in1,
    input  logic rst_n,
    input  logic period_done,
    output logic locked
);

    localparam int LW = width_for(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    generate
        if (!lock_legal(LOCK_CYCLES)) begin : g_lock_check
            $fatal(1, "cpu_clk_lock_mon: LOCK_CYCLES=%0d is illegal, must be >= 1", LOCK_CYCLES);
        end
    endgenerate

    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_next;

    // Advance on each completed period, holding once the target is reached.
    always_comb begin
        lock_cnt_next = lock_cnt;
        if (period_done && (lock_cnt != LOCK_MAX)) begin
            lock_cnt_next = lock_cnt + LW'(1);
        end
    end

    // Counter register and sticky flag; the flag rises on the reaching edge.
    always_ff @(posedge clk_in1) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            if (lock_cnt_next == LOCK_MAX) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_clk_gen.sv
// Integer divider deriving the CPU clock from the board clock, with a
// clock-enable strobe at each divided rising edge and a lock indicator.
module cpu_clk_gen
    import cpu_clk_gen_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk_in1,
    input  logic rst_n,
    output logic clk_out1,
    output logic ce_out,
    output logic locked
);

    localparam int HIGH = DIV / 2;
    localparam int CW   = width_for(DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH);

    generate
        if (!div_legal(DIV)) begin : g_div_check
            $fatal(1, "cpu_clk_gen: DIV=%0d is illegal, must be in %0d..%0d", DIV, DIV_MIN, DIV_MAX);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          running;
    logic          period_done;

    // Phase counter successor and period-complete detection.
    // The reset value DIV-1 wraps on the first edge after release; running
    // masks that wrap so only real period completions reach the lock monitor.
    always_comb begin
        cnt_next    = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        period_done = running && (cnt == CNT_MAX);
    end

    // Phase counter and registered outputs, all driven from the next count.
    always_ff @(posedge clk_in1) begin
        if (!rst_n) begin
            cnt      <= CNT_MAX;
            clk_out1 <= 1'b0;
            ce_out   <= 1'b0;
            running  <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            clk_out1 <= (cnt_next < CNT_HIGH);
            ce_out   <= (cnt_next == '0);
            running  <= 1'b1;
        end
    end

    cpu_clk_lock_mon #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_mon (
        .clk_in1    (clk_in1),
        .rst_n      (rst_n),
        .period_done(period_done),
        .locked     (locked)
    );

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Scoreboard bench: four divider configurations share one clock, each with its
// own reset; expectations come from edge counts since reset release.
module tb_cpu_clk_gen;

    localparam int N = 4;
    localparam int DIVS [N] = '{4, 5, 2, 3};
    localparam int LOCKS[N] = '{16, 16, 16, 1};
    localparam int CYCLES = 3000;

    typedef struct packed {
        logic c;
        logic e;
        logic l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  [N];
    logic clk_out[N];
    logic ce     [N];
    logic lk     [N];

    cpu_clk_gen #(.DIV(4), .LOCK_CYCLES(16)) u_div4 (
        .clk_in1(clk), .rst_n(rst_n[0]), .clk_out1(clk_out[0]), .ce_out(ce[0]), .locked(lk[0]));
    cpu_clk_gen #(.DIV(5), .LOCK_CYCLES(16)) u_div5 (
        .clk_in1(clk), .rst_n(rst_n[1]), .clk_out1(clk_out[1]), .ce_out(ce[1]), .locked(lk[1]));
    cpu_clk_gen #(.DIV(2), .LOCK_CYCLES(16)) u_div2 (
        .clk_in1(clk), .rst_n(rst_n[2]), .clk_out1(clk_out[2]), .ce_out(ce[2]), .locked(lk[2]));
    cpu_clk_gen #(.DIV(3), .LOCK_CYCLES(1)) u_div3 (
        .clk_in1(clk), .rst_n(rst_n[3]), .clk_out1(clk_out[3]), .ce_out(ce[3]), .locked(lk[3]));

    exp_t q[N][$];
    exp_t last_exp[N];
    logic have_exp = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   n_since [N];
    int   rst_hold[N];
    logic forced_done = 1'b0;

    // Expected outputs after an edge, given edges since release (0 = in reset).
    function automatic exp_t model(input int n, input int d, input int lc);
        exp_t r;
        r = '0;
        if (n > 0) begin
            r.c = (((n - 1) % d) < (d / 2));
            r.e = (((n - 1) % d) == 0);
            r.l = (n >= d * lc + 1);
        end
        return r;
    endfunction

    task automatic check1(input string name, input int inst, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d] @%0t: got %b expected %b", name, inst, $time, got, exp);
        end
    endtask

    // Stimulus: drive resets on the falling edge and queue what the next
    // rising edge must produce.
    initial begin
        for (int i = 0; i < N; i++) begin
            rst_n[i]    = 1'b0;
            n_since[i]  = 0;
            rst_hold[i] = 0;
        end
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            for (int i = 0; i < N; i++) begin
                logic r;
                r = 1'b1;
                if (cyc < 3) begin
                    r = 1'b0;
                end else if (i == 0 && !forced_done && n_since[0] >= 70 && ((n_since[0] - 1) % 4) == 0) begin
                    // one-cycle reset while clk_out1 is high and locked is set
                    r = 1'b0;
                    forced_done = 1'b1;
                end else if (rst_hold[i] > 0) begin
                    r = 1'b0;
                    rst_hold[i]--;
                end else if (cyc > 1500 && $urandom_range(0, 199) == 0) begin
                    r = 1'b0;
                    rst_hold[i] = int'($urandom_range(0, 2));
                end
                rst_n[i]   = r;
                n_since[i] = r ? n_since[i] + 1 : 0;
                q[i].push_back(model(n_since[i], DIVS[i], LOCKS[i]));
            end
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        for (int i = 0; i < N; i++) begin
            check1("queue_drained", i, logic'(q[i].size() == 0), 1'b1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Monitor: every rising edge presents new outputs; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0) begin
                    check1("queue_empty", i, 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q[i].pop_front();
                    last_exp[i] = e;
                    check1("clk_out1", i, clk_out[i], e.c);
                    check1("ce_out", i, ce[i], e.e);
                    check1("locked", i, lk[i], e.l);
                end
            end
            have_exp = 1'b1;
        end
    end

    // Divided clock must hold its value between rising edges.
    always @(negedge clk) begin
        if (have_exp) begin
            for (int i = 0; i < N; i++) begin
                check1("clk_out1_hold", i, clk_out[i], last_exp[i].c);
            end
        end
    end

endmodule
